// File: rtl/and_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module   : and_reduce_pipe
// Purpose  : Pipelined FANIN-ary AND/NAND reduction tree with valid/ready flow
//            control and a global stall.
// Revision : 1.0
// ============================================================================
module and_reduce_pipe #(
    parameter int WIDTH = 9,
    parameter int FANIN = 3
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             inv,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic             q,
    output logic             nq,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             busy
);

    function automatic int calc_stages(input int w, input int f);
        int n;
        int span;
        n    = 0;
        span = 1;
        for (int k = 0; k < 64; k++) begin
            if (span < w) begin
                span = span * f;
                n    = n + 1;
            end
        end
        return n;
    endfunction

    // Number of live bits after s tree levels (level 0 is the operand itself).
    function automatic int lvl_width(input int s);
        int w;
        w = WIDTH;
        for (int k = 0; k < s; k++) begin
            w = (w + FANIN - 1) / FANIN;
        end
        return w;
    endfunction

    function automatic int lvl_offset(input int s);
        int o;
        o = 0;
        for (int k = 0; k < s; k++) begin
            o = o + lvl_width(k);
        end
        return o;
    endfunction

    localparam int STAGES = calc_stages(WIDTH, FANIN);
    localparam int TOTAL  = lvl_offset(STAGES + 1);

    logic [TOTAL-1:0]  lvl;
    logic              adv;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] inv_q;
    logic [STAGES-1:0] inv_d;
    logic [STAGES-1:0] vld_in;
    logic [STAGES-1:0] inv_in;

    assign lvl[WIDTH-1:0] = i;

    assign out_vld = vld_q[STAGES-1];
    assign adv     = ~out_vld | out_rdy;
    assign in_rdy  = adv;
    assign busy    = |vld_q;
    assign q       = lvl[TOTAL-1] ^ inv_q[STAGES-1];
    assign nq      = ~q;

    if (STAGES > 1) begin : g_chain
        assign vld_in = {vld_q[STAGES-2:0], in_vld};
        assign inv_in = {inv_q[STAGES-2:0], inv};
    end else begin : g_single
        assign vld_in = in_vld;
        assign inv_in = inv;
    end

    // Side-band inv only moves with a real token so q keeps the last result.
    always_comb begin
        vld_d = vld_q;
        inv_d = inv_q;
        if (adv) begin
            vld_d = vld_in;
            inv_d = (inv_in & vld_in) | (inv_q & ~vld_in);
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            vld_q <= '0;
            inv_q <= '0;
        end else begin
            vld_q <= vld_d;
            inv_q <= inv_d;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int W_IN  = lvl_width(s);
        localparam int W_OUT = lvl_width(s + 1);
        localparam int O_IN  = lvl_offset(s);
        localparam int O_OUT = lvl_offset(s + 1);

        logic [W_OUT*FANIN-1:0] x_pad;
        logic [W_OUT-1:0]       dat_d;
        logic [W_OUT-1:0]       dat_q;

        // Missing group inputs are tied high so they never affect the AND.
        always_comb begin
            x_pad           = '1;
            x_pad[W_IN-1:0] = lvl[O_IN +: W_IN];
            dat_d           = '1;
            for (int j = 0; j < W_OUT; j++) begin
                dat_d[j] = &x_pad[j*FANIN +: FANIN];
            end
        end

        always_ff @(posedge ck) begin
            if (rst) begin
                dat_q <= '0;
            end else if (adv && vld_in[s]) begin
                dat_q <= dat_d;
            end
        end

        assign lvl[O_OUT +: W_OUT] = dat_q;
    end

endmodule
`default_nettype wire
